// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared definitions for the PS/2 scan sequencer:
//   - scan-code constants: prefixes, ignored bytes and arrow key codes
//   - FSM state encoding
//   - the 10-bit queued event layout {ext, brk, key[7:0]}
//   - arrow_mask(): maps an arrow scan code to its ARROW_HELD bit
package ps2_scan_sequencer_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_NUL   = 8'h00;
  localparam logic [7:0] SC_OVR   = 8'hFF;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] key;
  } evt_t;

  localparam int unsigned EVT_W = $bits(evt_t);

  // ARROW_HELD bit order: {up, down, left, right}
  function automatic logic [3:0] arrow_mask(input logic [7:0] key);
    logic [3:0] m;
    m = '0;
    case (key)
      SC_UP:    m = 4'b1000;
      SC_DOWN:  m = 4'b0100;
      SC_LEFT:  m = 4'b0010;
      SC_RIGHT: m = 4'b0001;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Byte-in / event-out bus of the PS/2 scan sequencer.
//   CODE_VALID/CODE/CODE_ERR : byte strobe from the PS/2 frame receiver
//   EVT_VALID/EVT_READY      : valid/ready handshake for the event queue head
//   EVT_KEY/EVT_EXT/EVT_BREAK: head event contents
// slave  = the sequencer, master = the receiver/consumer side.
interface ps2_scan_sequencer_if;
  logic       CODE_VALID;
  logic [7:0] CODE;
  logic       CODE_ERR;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_KEY;
  logic       EVT_EXT;
  logic       EVT_BREAK;

  modport slave (
    input  CODE_VALID, CODE, CODE_ERR, EVT_READY,
    output EVT_VALID, EVT_KEY, EVT_EXT, EVT_BREAK
  );

  modport master (
    output CODE_VALID, CODE, CODE_ERR, EVT_READY,
    input  EVT_VALID, EVT_KEY, EVT_EXT, EVT_BREAK
  );
endinterface

// File: rtl/ps2_scan_sequencer_event_fifo.sv
// Show-ahead synchronous FIFO for key events.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write request and data
//   pop_i        : read request; ignored while empty
//   data_o       : head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
//   drop_o       : pulse when a push is lost (full, no simultaneous pop)
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan sequencer: turns received scan bytes into key events.
//   CLK, RST   : clock, synchronous active-high reset
//   bus        : byte strobe in, event valid/ready queue head out
//   ARROW_HELD : {up,down,left,right} extended arrows currently held
//   OVERFLOW   : sticky, an event was dropped on a full queue
// Decodes E0/F0 prefixes, aborts partial sequences on error or timeout,
// filters typematic repeats and queues events.
module ps2_scan_sequencer
  import ps2_scan_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYC   = 250000,
  parameter bit          REPEAT_FILTER = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  ps2_scan_sequencer_if.slave   bus,
  output logic [3:0]            ARROW_HELD,
  output logic                  OVERFLOW
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             emit_q, emit_d;
  evt_t             evt_q, evt_d;
  logic [8:0]       last_q, last_d;       // {ext, key} of last make
  logic             last_vld_q, last_vld_d;
  logic [3:0]       arrow_q, arrow_d;
  logic             ovf_q;

  logic             cand_vld;
  evt_t             cand;

  evt_t             head;
  logic [EVT_W-1:0] head_raw;
  logic             fifo_full, fifo_empty, fifo_drop;

  // Prefix decode and timeout
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    cand_vld = 1'b0;
    cand     = '0;
    if (bus.CODE_VALID) begin
      tmo_d = '0;
      if (bus.CODE_ERR) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.CODE == SC_EXT)      state_d = ST_EXT;
            else if (bus.CODE == SC_BRK) state_d = ST_BRK;
            else if (bus.CODE != SC_NUL && bus.CODE != SC_OVR) begin
              cand_vld = 1'b1;
              cand     = '{ext: 1'b0, brk: 1'b0, key: bus.CODE};
            end
          end
          ST_EXT: begin
            if (bus.CODE == SC_BRK)      state_d = ST_EXTBRK;
            else if (bus.CODE == SC_EXT) state_d = ST_EXT;
            else begin
              state_d  = ST_IDLE;
              cand_vld = 1'b1;
              cand     = '{ext: 1'b1, brk: 1'b0, key: bus.CODE};
            end
          end
          ST_BRK, ST_EXTBRK: begin
            state_d = ST_IDLE;
            if (bus.CODE != SC_EXT && bus.CODE != SC_BRK) begin
              cand_vld = 1'b1;
              cand     = '{ext: (state_q == ST_EXTBRK), brk: 1'b1, key: bus.CODE};
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Repeat filter and arrow tracking act on the decoded candidate
  always_comb begin
    emit_d     = 1'b0;
    evt_d      = evt_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    arrow_d    = arrow_q;
    if (cand_vld) begin
      if (!cand.brk) begin
        if (!(REPEAT_FILTER && last_vld_q && last_q == {cand.ext, cand.key})) begin
          emit_d     = 1'b1;
          evt_d      = cand;
          last_d     = {cand.ext, cand.key};
          last_vld_d = 1'b1;
          if (cand.ext) arrow_d = arrow_q | arrow_mask(cand.key);
        end
      end else begin
        emit_d = 1'b1;
        evt_d  = cand;
        if (last_vld_q && last_q == {cand.ext, cand.key}) last_vld_d = 1'b0;
        if (cand.ext) arrow_d = arrow_q & ~arrow_mask(cand.key);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      emit_q     <= 1'b0;
      evt_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      arrow_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      emit_q     <= emit_d;
      evt_q      <= evt_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      arrow_q    <= arrow_d;
      ovf_q      <= ovf_q | fifo_drop;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (emit_q),
    .data_i  (evt_q),
    .pop_i   (bus.EVT_READY),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // Storage is not reset, so the head is masked while the queue is empty.
  assign head          = fifo_empty ? evt_t'('0) : evt_t'(head_raw);
  assign bus.EVT_VALID = ~fifo_empty;
  assign bus.EVT_KEY   = head.key;
  assign bus.EVT_EXT   = head.ext;
  assign bus.EVT_BREAK = head.brk;
  assign ARROW_HELD    = arrow_q;
  assign OVERFLOW      = ovf_q;

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
module tb_ps2_scan_sequencer;
  logic       clk;
  logic       rst;
  logic [3:0] arrow;
  logic       ovf;
  int         vectors;
  int         miscompares;

  ps2_scan_sequencer_if bus();

  ps2_scan_sequencer #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYC   (20),
    .REPEAT_FILTER (1'b1)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .ARROW_HELD (arrow),
    .OVERFLOW   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic err);
    bus.CODE       = c;
    bus.CODE_ERR   = err;
    bus.CODE_VALID = 1'b1;
    tick(1);
    bus.CODE_VALID = 1'b0;
    bus.CODE_ERR   = 1'b0;
  endtask

  // Wait (bounded) for a head event, compare it, then accept it.
  task automatic expect_evt(input string tag, input logic ext, input logic brk, input logic [7:0] key);
    for (int i = 0; i < 10 && !bus.EVT_VALID; i++) tick(1);
    check({tag, "_valid"}, 32'(bus.EVT_VALID), 32'd1);
    check({tag, "_evt"}, {22'd0, bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_KEY}, {22'd0, ext, brk, key});
    bus.EVT_READY = 1'b1;
    tick(1);
    bus.EVT_READY = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    bus.CODE_VALID = 1'b0;
    bus.CODE       = 8'h00;
    bus.CODE_ERR   = 1'b0;
    bus.EVT_READY  = 1'b0;
    rst            = 1'b1;
    tick(3);
    rst = 1'b0;

    check("rst_valid", 32'(bus.EVT_VALID), 32'd0);
    check("rst_key", 32'(bus.EVT_KEY), 32'd0);
    check("rst_arrow", 32'(arrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // 1: plain make with latency check, then break
    send(8'h1C, 1'b0);
    check("t1_lat_early", 32'(bus.EVT_VALID), 32'd0);
    tick(1);
    check("t1_lat_valid", 32'(bus.EVT_VALID), 32'd1);
    expect_evt("t1_make", 1'b0, 1'b0, 8'h1C);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    expect_evt("t1_break", 1'b0, 1'b1, 8'h1C);
    tick(2);
    check("t1_empty", 32'(bus.EVT_VALID), 32'd0);

    // 2: extended left arrow press and release
    send(8'hE0, 1'b0);
    send(8'h6B, 1'b0);
    tick(1);
    check("t2_arrow_set", 32'(arrow), 32'h2);
    expect_evt("t2_make", 1'b1, 1'b0, 8'h6B);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h6B, 1'b0);
    tick(1);
    check("t2_arrow_clr", 32'(arrow), 32'h0);
    expect_evt("t2_break", 1'b1, 1'b1, 8'h6B);

    // 3: typematic repeats filtered
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    tick(2);
    expect_evt("t3_make", 1'b0, 1'b0, 8'h1C);
    expect_evt("t3_break", 1'b0, 1'b1, 8'h1C);
    tick(3);
    check("t3_empty", 32'(bus.EVT_VALID), 32'd0);

    // 4: overflow with consumer stalled
    check("t4_ovf_pre", 32'(ovf), 32'd0);
    send(8'h15, 1'b0);
    send(8'h1D, 1'b0);
    send(8'h24, 1'b0);
    send(8'h2D, 1'b0);
    send(8'h2C, 1'b0);
    tick(3);
    check("t4_ovf", 32'(ovf), 32'd1);
    check("t4_head_stable", 32'(bus.EVT_KEY), 32'h15);
    expect_evt("t4_q0", 1'b0, 1'b0, 8'h15);
    expect_evt("t4_q1", 1'b0, 1'b0, 8'h1D);
    expect_evt("t4_q2", 1'b0, 1'b0, 8'h24);
    expect_evt("t4_q3", 1'b0, 1'b0, 8'h2D);
    tick(2);
    check("t4_empty", 32'(bus.EVT_VALID), 32'd0);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);

    // 5: E0 prefix times out, following byte is a plain make
    send(8'hE0, 1'b0);
    tick(25);
    send(8'h74, 1'b0);
    expect_evt("t5_evt", 1'b0, 1'b0, 8'h74);
    check("t5_arrow", 32'(arrow), 32'h0);

    // 6: error byte aborts E0,F0; FSM back to IDLE
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h6B, 1'b1);
    tick(4);
    check("t6_err_none", 32'(bus.EVT_VALID), 32'd0);
    send(8'h1C, 1'b0);
    expect_evt("t6_idle_make", 1'b0, 1'b0, 8'h1C);

    // 6b: reset with a held arrow, a queued event and a pending prefix
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    tick(1);
    check("t6_arrow_up", 32'(arrow), 32'h8);
    send(8'h35, 1'b0);
    send(8'hE0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_valid", 32'(bus.EVT_VALID), 32'd0);
    check("t6_rst_key", 32'(bus.EVT_KEY), 32'd0);
    check("t6_rst_arrow", 32'(arrow), 32'd0);
    check("t6_rst_ovf", 32'(ovf), 32'd0);
    tick(3);
    check("t6_rst_quiet", 32'(bus.EVT_VALID), 32'd0);
    send(8'h74, 1'b0);
    expect_evt("t6_post_rst", 1'b0, 1'b0, 8'h74);
    check("t6_post_arrow", 32'(arrow), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
